// File: rtl/div_seq_ctrl_pkg.sv
// div_seq_ctrl_pkg: shared state encodings, widths and execute-stage divide opcodes.
package div_seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] ITER_LAST = 5'd31;
  localparam logic [7:0] EXE_DIV_OP = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
endpackage

// File: rtl/div_seq_ctrl_iter.sv
// div_iter_core: restoring radix-2 divider datapath; exposes the post-step values so the
// controller can capture the final result on the same edge as the last step.
module div_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotNext,
  output logic [WIDTH-1:0] remNext
);
  logic [WIDTH-1:0] remQ, quotQ, divQ;
  logic fits;
  // shifted remainder needs one extra bit; the difference itself always fits in WIDTH
  assign fits = {remQ, quotQ[WIDTH-1]} >= {1'b0, divQ};
  assign remNext = fits ? {remQ[WIDTH-2:0], quotQ[WIDTH-1]} - divQ : {remQ[WIDTH-2:0], quotQ[WIDTH-1]};
  assign quotNext = {quotQ[WIDTH-2:0], fits};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remQ <= '0;
      quotQ <= '0;
      divQ <= '0;
    end else if (load) begin
      remQ <= '0;
      quotQ <= dividend;
      divQ <= divisor;
    end else if (step) begin
      remQ <= remNext;
      quotQ <= quotNext;
    end
  end
endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle DIV/DIVU sequencer with stall, annul and divide-by-zero handling.
// Optional DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               annul_i,
  output logic               stall_o,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);
  state_t state;
  logic [CNT_W-1:0] count;
  logic negQ, negR, accept, zeroDiv, earlyOut;
  logic [WIDTH-1:0] absA, absB, quotNext, remNext;
  assign absA = (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign absB = (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;
  assign zeroDiv = opb_i == '0;
`ifdef DIV_EARLY_OUT_EN
  assign earlyOut = !zeroDiv && absA < absB;
`else
  assign earlyOut = 1'b0;
`endif
  assign accept = state == IDLE && start_i && !annul_i;
  // reset gating keeps the hazard unit quiet while start_i is still held
  assign stall_o = !rst && !annul_i && (accept || state == RUN);
  assign busy_o = state != IDLE;
  assign ready_o = state == DONE && !annul_i;
  div_iter_core #(.WIDTH(WIDTH)) core (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .step(state == RUN && !annul_i),
    .dividend(absA),
    .divisor(absB),
    .quotNext(quotNext),
    .remNext(remNext)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      negQ <= 1'b0;
      negR <= 1'b0;
      result_o <= '0;
    end else if (annul_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          negQ <= signed_i && (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
          negR <= signed_i && opa_i[WIDTH-1];
          count <= ITER_LAST;
          state <= (zeroDiv || earlyOut) ? DONE : RUN;
          if (zeroDiv) result_o <= {opa_i, {WIDTH{1'b1}}};
          else if (earlyOut) result_o <= {opa_i, {WIDTH{1'b0}}};
        end
        RUN: begin
          count <= count - 1'b1;
          if (count == '0) begin
            state <= DONE;
            result_o <= {negR ? -remNext : remNext, negQ ? -quotNext : quotNext};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed cycle-accurate checks of latency, stall, sign rules, annul and reset.
module tb_div_seq_ctrl;
  logic clk = 1'b0, rst, start_i, signed_i, annul_i;
  logic [31:0] opa_i, opb_i;
  logic stall_o, busy_o, ready_o;
  logic [63:0] result_o;
  int total = 0, passed = 0, fails = 0;
`ifdef DIV_EARLY_OUT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 33;
`endif
  div_seq_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i), .opa_i(opa_i), .opb_i(opb_i),
    .annul_i(annul_i), .stall_o(stall_o), .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask
  // issue at the current cycle (cycle 0) and check stall/ready every cycle up to the ready cycle
  task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [63:0] expRes);
    start_i = 1'b1; signed_i = sgn; opa_i = a; opb_i = b;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (c == 0 || c == lat - 1 || c == lat) chk({tag, "_stall"}, stall_o, c < lat);
      else if (stall_o !== 1'b1) chk({tag, "_stall_mid"}, stall_o, 1'b1);
      if (c == lat) chk({tag, "_ready"}, ready_o, 1'b1);
      else if (ready_o !== 1'b0) chk({tag, "_early_ready"}, ready_o, 1'b0);
      if (c == lat) chk({tag, "_result"}, result_o, expRes);
      nextCyc();
    end
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_after"}, {busy_o, ready_o}, 2'b00);
    nextCyc();
  endtask
  initial begin
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0; opa_i = '0; opb_i = '0;
    #2;
    chk("rst_outputs", {stall_o, busy_o, ready_o, result_o}, 67'd0);
    nextCyc();
    rst = 1'b0;
    nextCyc();
    runDiv("u100_7", 1'b0, 32'd100, 32'd7, 33, {32'h2, 32'hE});
    runDiv("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h2, 33, {32'hFFFFFFFF, 32'hFFFFFFFD});
    runDiv("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, {32'h0, 32'h80000000});
    runDiv("u_dz", 1'b0, 32'd5, 32'd0, 1, {32'h5, 32'hFFFFFFFF});
    start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd100; opb_i = 32'd7;
    for (int c = 0; c < 10; c++) nextCyc();
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    chk("annul_stall", stall_o, 1'b0);
    chk("annul_ready", ready_o, 1'b0);
    chk("annul_busy_in", busy_o, 1'b1);
    nextCyc();
    annul_i = 1'b0;
    @(negedge clk);
    chk("annul_idle", {stall_o, busy_o, ready_o}, 3'b000);
    nextCyc();
    runDiv("u9_3", 1'b0, 32'd9, 32'd3, 33, {32'h0, 32'h3});
    runDiv("u3_10", 1'b0, 32'd3, 32'd10, SMALL_LAT, {32'h3, 32'h0});
    runDiv("s_m3_5", 1'b1, 32'hFFFFFFFD, 32'd5, SMALL_LAT, {32'hFFFFFFFD, 32'h0});
    start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd100; opb_i = 32'd7;
    for (int c = 0; c < 5; c++) nextCyc();
    @(negedge clk);
    chk("pre_rst_busy", {stall_o, busy_o}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {stall_o, busy_o, ready_o, result_o}, 67'd0);
    nextCyc();
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", {stall_o, busy_o, ready_o}, 3'b000);
    nextCyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
